// File: rtl/counter_game_driver.sv
// -----------------------------------------------------------------------------
// counter_game_driver
//
// Game master / self-test sequencer for the counter game block. It sits on the
// far side of the counter interface: it drives the counter's mode, load strobe
// and load value, watches the counter's WINNER/LOSER/GAMEOVER/WHO outputs, and
// on a start pulse walks a fixed 12-round sweep (ctrl 0..3 x loadValue
// {0, 1, all-ones}), emitting one record per finished round.
//
// Ports
//   clk, rst_l          clock (rising edge), asynchronous active-low reset
//   start               launch a sweep (only looked at while idle)
//   abort               stop the sweep; back to idle on the next cycle
//   ctrl, INIT,
//   loadValue           counter mode, load strobe, load value
//   LOSER, WINNER,
//   WHO, GAMEOVER       counter outputs consumed by the sequencer
//   busy                sweep in progress
//   done                one-cycle pulse at the end of a sweep or after abort
//   rec_valid           one-cycle pulse per finished round
//   rec_round           round index 0..11 (ctrl*3 + loadValue selector)
//   rec_who             WHO captured at GAMEOVER, 0 when the round timed out
//   rec_timeout         round ended because GAMEOVER never came
//   rec_wins,
//   rec_losses          saturating WINNER / LOSER pulse counts for the round
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module counter_game_driver #(
    parameter int COUNTER_SIZE  = 4,
    parameter int ROUND_TIMEOUT = 1024,
    parameter int TALLY_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    start,
    input  logic                    abort,
    output logic [1:0]              ctrl,
    output logic                    INIT,
    output logic [COUNTER_SIZE-1:0] loadValue,
    input  logic                    LOSER,
    input  logic                    WINNER,
    input  logic [1:0]              WHO,
    input  logic                    GAMEOVER,
    output logic                    busy,
    output logic                    done,
    output logic                    rec_valid,
    output logic [3:0]              rec_round,
    output logic [1:0]              rec_who,
    output logic                    rec_timeout,
    output logic [TALLY_WIDTH-1:0]  rec_wins,
    output logic [TALLY_WIDTH-1:0]  rec_losses
);

    localparam int TIMER_W = ($clog2(ROUND_TIMEOUT) > 0) ? $clog2(ROUND_TIMEOUT) : 1;
    // Value of the RUN-cycle timer on the last RUN cycle a round is allowed.
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ROUND_TIMEOUT - 1);
    localparam logic [3:0]         LAST_ROUND = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RECORD,
        S_FINISH
    } state_e;

    // Counter mode for a round: round / 3.
    function automatic logic [1:0] round_ctrl(input logic [3:0] r);
        logic [1:0] c;
        if (r < 4'd3)      c = 2'd0;
        else if (r < 4'd6) c = 2'd1;
        else if (r < 4'd9) c = 2'd2;
        else               c = 2'd3;
        return c;
    endfunction

    // Load value for a round: 0, 1 or all-ones for round % 3 = 0, 1, 2.
    function automatic logic [COUNTER_SIZE-1:0] round_lv(input logic [3:0] r);
        logic [COUNTER_SIZE-1:0] v;
        case (r)
            4'd0, 4'd3, 4'd6, 4'd9:  v = '0;
            4'd1, 4'd4, 4'd7, 4'd10: v = COUNTER_SIZE'(1);
            default:                 v = '1;
        endcase
        return v;
    endfunction

    function automatic logic [TALLY_WIDTH-1:0] sat_inc(input logic [TALLY_WIDTH-1:0] v,
                                                       input logic                   en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    state_e                  state_q, state_d;
    logic [3:0]              round_q, round_d;
    logic                    load_second_q, load_second_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [TALLY_WIDTH-1:0]  wins_q, wins_d;
    logic [TALLY_WIDTH-1:0]  losses_q, losses_d;

    logic [1:0]              ctrl_q, ctrl_d;
    logic                    init_q, init_d;
    logic [COUNTER_SIZE-1:0] lv_q, lv_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rec_valid_q, rec_valid_d;
    logic [3:0]              rec_round_q, rec_round_d;
    logic [1:0]              rec_who_q, rec_who_d;
    logic                    rec_timeout_q, rec_timeout_d;
    logic [TALLY_WIDTH-1:0]  rec_wins_q, rec_wins_d;
    logic [TALLY_WIDTH-1:0]  rec_losses_q, rec_losses_d;

    logic [3:0] round_inc;
    logic       timeout_hit;

    assign round_inc   = round_q + 4'd1;
    assign timeout_hit = (timer_q == TIMER_LAST);

    always_comb begin
        // NOTE: every _d gets its default first, so no path through the case can infer a latch.
        state_d       = state_q;
        round_d       = round_q;
        load_second_d = 1'b0;
        timer_d       = timer_q;
        wins_d        = wins_q;
        losses_d      = losses_q;
        ctrl_d        = ctrl_q;
        init_d        = 1'b0;
        lv_d          = lv_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        rec_valid_d   = 1'b0;
        rec_round_d   = rec_round_q;
        rec_who_d     = rec_who_q;
        rec_timeout_d = rec_timeout_q;
        rec_wins_d    = rec_wins_q;
        rec_losses_d  = rec_losses_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    round_d  = 4'd0;
                    init_d   = 1'b1;
                    ctrl_d   = round_ctrl(4'd0);
                    lv_d     = round_lv(4'd0);
                    busy_d   = 1'b1;
                    wins_d   = '0;
                    losses_d = '0;
                end
            end

            // Two INIT cycles; load_second_q marks the second one. Counter
            // outputs are not looked at here.
            S_LOAD: begin
                if (!load_second_q) begin
                    init_d        = 1'b1;
                    load_second_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                    timer_d = '0;
                end
            end

            S_RUN: begin
                wins_d   = sat_inc(wins_q, WINNER);
                losses_d = sat_inc(losses_q, LOSER);
                // GAMEOVER on the last allowed cycle still counts as a real finish.
                if (GAMEOVER || timeout_hit) begin
                    state_d       = S_RECORD;
                    rec_valid_d   = 1'b1;
                    rec_round_d   = round_q;
                    rec_who_d     = GAMEOVER ? WHO : 2'b00;
                    rec_timeout_d = !GAMEOVER;
                    rec_wins_d    = wins_d;
                    rec_losses_d  = losses_d;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_RECORD: begin
                if (round_q != LAST_ROUND) begin
                    state_d  = S_LOAD;
                    round_d  = round_inc;
                    init_d   = 1'b1;
                    ctrl_d   = round_ctrl(round_inc);
                    lv_d     = round_lv(round_inc);
                    wins_d   = '0;
                    losses_d = '0;
                end else begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                ctrl_d  = 2'd0;
                lv_d    = '0;
            end

            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything decided above; the last record is kept.
        if (abort && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            init_d        = 1'b0;
            ctrl_d        = 2'd0;
            lv_d          = '0;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            rec_valid_d   = 1'b0;
            rec_round_d   = rec_round_q;
            rec_who_d     = rec_who_q;
            rec_timeout_d = rec_timeout_q;
            rec_wins_d    = rec_wins_q;
            rec_losses_d  = rec_losses_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= S_IDLE;
            round_q       <= 4'd0;
            load_second_q <= 1'b0;
            timer_q       <= '0;
            wins_q        <= '0;
            losses_q      <= '0;
            ctrl_q        <= 2'd0;
            init_q        <= 1'b0;
            lv_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rec_valid_q   <= 1'b0;
            rec_round_q   <= 4'd0;
            rec_who_q     <= 2'b00;
            rec_timeout_q <= 1'b0;
            rec_wins_q    <= '0;
            rec_losses_q  <= '0;
        end else begin
            state_q       <= state_d;
            round_q       <= round_d;
            load_second_q <= load_second_d;
            timer_q       <= timer_d;
            wins_q        <= wins_d;
            losses_q      <= losses_d;
            ctrl_q        <= ctrl_d;
            init_q        <= init_d;
            lv_q          <= lv_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            rec_valid_q   <= rec_valid_d;
            rec_round_q   <= rec_round_d;
            rec_who_q     <= rec_who_d;
            rec_timeout_q <= rec_timeout_d;
            rec_wins_q    <= rec_wins_d;
            rec_losses_q  <= rec_losses_d;
        end
    end

    assign ctrl        = ctrl_q;
    assign INIT        = init_q;
    assign loadValue   = lv_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rec_valid   = rec_valid_q;
    assign rec_round   = rec_round_q;
    assign rec_who     = rec_who_q;
    assign rec_timeout = rec_timeout_q;
    assign rec_wins    = rec_wins_q;
    assign rec_losses  = rec_losses_q;

endmodule

// File: tb/tb_counter_game_driver.sv
// -----------------------------------------------------------------------------
// tb_counter_game_driver
//
// A behavioural counter model answers the driver: after INIT falls it drives
// WINNER for the first nw RUN cycles, LOSER for the first nl RUN cycles, and
// GAMEOVER/WHO on RUN cycle go_at (0 = never), all per round. Each scenario
// pushes the records it expects into sb_q; a monitor pops and compares on
// every rec_valid and also checks the INIT strobe shape and round spacing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_counter_game_driver;

    localparam int CS = 4;
    localparam int RT = 1024;
    localparam int TW = 8;
    localparam int TALLY_MAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          start;
    logic          abort;
    logic [1:0]    ctrl;
    logic          INIT;
    logic [CS-1:0] loadValue;
    logic          LOSER;
    logic          WINNER;
    logic [1:0]    WHO;
    logic          GAMEOVER;
    logic          busy;
    logic          done;
    logic          rec_valid;
    logic [3:0]    rec_round;
    logic [1:0]    rec_who;
    logic          rec_timeout;
    logic [TW-1:0] rec_wins;
    logic [TW-1:0] rec_losses;

    always #5 clk = ~clk;

    counter_game_driver #(
        .COUNTER_SIZE (CS),
        .ROUND_TIMEOUT(RT),
        .TALLY_WIDTH  (TW)
    ) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .start      (start),
        .abort      (abort),
        .ctrl       (ctrl),
        .INIT       (INIT),
        .loadValue  (loadValue),
        .LOSER      (LOSER),
        .WINNER     (WINNER),
        .WHO        (WHO),
        .GAMEOVER   (GAMEOVER),
        .busy       (busy),
        .done       (done),
        .rec_valid  (rec_valid),
        .rec_round  (rec_round),
        .rec_who    (rec_who),
        .rec_timeout(rec_timeout),
        .rec_wins   (rec_wins),
        .rec_losses (rec_losses)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-round counter behaviour ----------------
    int         go_at   [12];
    int         nw      [12];
    int         nl      [12];
    logic [1:0] who_cfg [12];

    task automatic cfg_all(input int go, input logic [1:0] w);
        for (int r = 0; r < 12; r++) begin
            go_at[r]   = go;
            who_cfg[r] = w;
            nw[r]      = 0;
            nl[r]      = 0;
        end
    endtask

    function automatic int round_of(input logic [1:0] c, input logic [CS-1:0] lv);
        int idx;
        idx = (lv == '0) ? 0 : ((lv == CS'(1)) ? 1 : 2);
        return int'(c) * 3 + idx;
    endfunction

    function automatic logic [CS-1:0] exp_lv(input int r);
        logic [CS-1:0] v;
        if (r % 3 == 0)      v = '0;
        else if (r % 3 == 1) v = CS'(1);
        else                 v = '1;
        return v;
    endfunction

    int run_n = 0;
    bit armed = 1'b0;

    always @(negedge clk) begin
        int r;
        WINNER   = 1'b0;
        LOSER    = 1'b0;
        GAMEOVER = 1'b0;
        WHO      = 2'b00;
        if (!rst_l || !busy) begin
            armed = 1'b0;
            run_n = 0;
        end else if (INIT) begin
            armed = 1'b1;
            run_n = 0;
        end else if (armed) begin
            run_n++;
            r = round_of(ctrl, loadValue);
            if (run_n <= nw[r]) WINNER = 1'b1;
            if (run_n <= nl[r]) LOSER  = 1'b1;
            if (run_n == go_at[r]) begin
                GAMEOVER = 1'b1;
                WHO      = who_cfg[r];
                armed    = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int round;
        int who;
        int to;
        int wins;
        int losses;
        int lat;   // cycles from RUN cycle 1 to the rec_valid cycle, inclusive
    } exp_t;

    exp_t sb_q[$];

    function automatic int sat(input int v);
        return (v > TALLY_MAX) ? TALLY_MAX : v;
    endfunction

    task automatic push_round(input int r);
        exp_t e;
        int   span;
        e.round = r;
        if (go_at[r] >= 1 && go_at[r] <= RT) begin
            e.who = who_cfg[r];
            e.to  = 0;
            span  = go_at[r];
        end else begin
            e.who = 0;
            e.to  = 1;
            span  = RT;
        end
        e.lat    = span + 1;
        e.wins   = sat((nw[r] < span) ? nw[r] : span);
        e.losses = sat((nl[r] < span) ? nl[r] : span);
        sb_q.push_back(e);
    endtask

    task automatic push_range(input int first, input int last);
        for (int r = first; r <= last; r++) push_round(r);
    endtask

    // ---------------- monitor ----------------
    int cyc          = 0;
    int run_start    = 0;
    int last_rec_cyc = -100;
    int init_len     = 0;
    bit prev_init    = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_l) begin
            prev_init = 1'b0;
            init_len  = 0;
        end else begin
            if (INIT) begin
                init_len++;
                if (sb_q.size() > 0) begin
                    check("init_ctrl", 32'(ctrl), 32'(sb_q[0].round / 3));
                    check("init_loadValue", 32'(loadValue), 32'(exp_lv(sb_q[0].round)));
                    if (!prev_init && sb_q[0].round > 0)
                        check("rec_to_init_gap", cyc - last_rec_cyc, 1);
                end
            end else if (prev_init) begin
                check("init_len", init_len, 2);
                init_len  = 0;
                run_start = cyc;
            end
            if (rec_valid) begin
                if (sb_q.size() == 0) begin
                    check("rec_with_empty_sb", 32'(rec_valid), 0);
                end else begin
                    e = sb_q.pop_front();
                    check("rec_round", 32'(rec_round), e.round);
                    check("rec_who", 32'(rec_who), e.who);
                    check("rec_timeout", 32'(rec_timeout), e.to);
                    check("rec_wins", 32'(rec_wins), e.wins);
                    check("rec_losses", 32'(rec_losses), e.losses);
                    check("rec_latency", cyc - run_start + 1, e.lat);
                    check("busy_at_rec", 32'(busy), 1);
                end
                last_rec_cyc = cyc;
            end
            prev_init = INIT;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic launch();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_sweep(input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 1);
        check("sb_empty_at_done", sb_q.size(), 0);
        check("rec_round_at_done", 32'(rec_round), 11);
        check("busy_during_done", 32'(busy), 1);
        check("ctrl_during_done", 32'(ctrl), 3);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);
        check("busy_after_done", 32'(busy), 0);
        check("ctrl_after_done", 32'(ctrl), 0);
        check("init_after_done", 32'(INIT), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 32'(ctrl), 0);
        check({tag, "_INIT"}, 32'(INIT), 0);
        check({tag, "_loadValue"}, 32'(loadValue), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_rec_valid"}, 32'(rec_valid), 0);
        check({tag, "_rec_fields"},
              {14'd0, rec_round, rec_who, rec_timeout, rec_wins, rec_losses}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;
        rst_l = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_all(10, 2'b10);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_l = 1'b1;
        @(negedge clk);

        // Full sweep; round 0 also carries 3 WINNER / 2 LOSER pulses.
        cfg_all(10, 2'b10);
        nw[0] = 3; nl[0] = 2; who_cfg[0] = 2'b01;
        push_range(0, 11);
        launch();
        finish_sweep(3000);

        // Timeout, GAMEOVER on the final allowed cycle, tally saturation.
        cfg_all(5, 2'b01);
        go_at[0] = 0;    nw[0] = 2;
        go_at[1] = RT;   who_cfg[1] = 2'b11; nw[1] = 1; nl[1] = 1;
        go_at[2] = 400;  nw[2] = 300; nl[2] = 4;
        push_range(0, 11);
        launch();
        finish_sweep(5000);

        // Abort during round 5 RUN.
        cfg_all(3, 2'b10);
        go_at[5] = 0;
        push_range(0, 4);
        launch();
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (busy && !INIT && ctrl == 2'd1 && loadValue == '1) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_round5_run", 32'(found), 1);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_INIT", 32'(INIT), 0);
        check("abort_ctrl", 32'(ctrl), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 1);
        check("abort_rec_valid", 32'(rec_valid), 0);
        check("abort_sb_empty", sb_q.size(), 0);
        @(negedge clk);
        check("abort_done_one_cycle", 32'(done), 0);
        check("abort_stays_idle", 32'(busy), 0);

        // Restart after abort begins again at round 0.
        cfg_all(2, 2'b11);
        push_range(0, 11);
        launch();
        finish_sweep(2000);

        // Asynchronous reset during LOAD of round 2.
        cfg_all(4, 2'b01);
        push_range(0, 1);
        launch();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (INIT && ctrl == 2'd0 && loadValue == '1) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_round2_load", 32'(found), 1);
        #2 rst_l = 1'b0;
        #1 check_all_zero("async_reset");
        check("reset_sb_empty", sb_q.size(), 0);
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_after_reset_busy", 32'(busy), 0);
        check("idle_after_reset_INIT", 32'(INIT), 0);

        // start pulses while busy are ignored: still exactly 12 rounds.
        cfg_all(10, 2'b10);
        push_range(0, 11);
        launch();
        repeat (20) @(negedge clk);
        pulse_start();
        repeat (40) @(negedge clk);
        pulse_start();
        finish_sweep(2000);
        repeat (30) @(negedge clk);
        check("no_restart_busy", 32'(busy), 0);
        check("no_extra_records", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
